// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the divider bank.
//   CNT_W_DEF   : default counter / divisor width in bits
//   DIV_RST_DEF : divisor every channel starts from after reset
//   DIV_PARK    : divisor value that parks a channel (no ticks, o_clk frozen)
//   mode_e      : per-channel operating mode for one clock edge
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 10;
  localparam int DIV_PARK    = 0;

  // What a channel does on the coming edge, in priority order:
  // disabled, resynchronising, parked, or counting normally.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SYNC = 2'd1,
    MODE_PARK = 2'd2,
    MODE_RUN  = 2'd3
  } mode_e;

endpackage

// File: rtl/div_chan.sv
// -----------------------------------------------------------------------------
// div_chan
// One divider channel: counter, active and shadow divisors, commit logic and
// registered tick / divided-clock / pending outputs.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous reset, active-high
//   i_en       channel run enable
//   i_sync     restart the counter together with every other channel
//   i_wr       divisor write strobe already decoded for this channel
//   i_wr_div   new divisor value (DIV_PARK parks the channel)
//   o_tick     1-cycle pulse on each terminal count
//   o_clk      toggles on each terminal count (period 2*divisor)
//   o_pending  a shadow divisor is waiting to be committed
// -----------------------------------------------------------------------------
module div_chan
  import div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_tick,
  output logic             o_clk,
  output logic             o_pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             pend_q, pend_d;

  mode_e mode;
  logic  terminal;
  logic  commit;

  // Disable beats sync, sync beats a parked divisor, so a disabled channel
  // always idles with its outputs low.
  always_comb begin
    mode = MODE_RUN;
    if (!i_en) begin
      mode = MODE_OFF;
    end else if (i_sync) begin
      mode = MODE_SYNC;
    end else if (div_act_q == CNT_W'(DIV_PARK)) begin
      mode = MODE_PARK;
    end
  end

  // Terminal count is only honoured while running, so sync can never be
  // overridden by a coincident terminal count.
  assign terminal = (mode == MODE_RUN) && (cnt_q == div_act_q - CNT_W'(1));

  // The shadow divisor only moves to the active one at a period boundary or
  // whenever the channel is not actively counting, so no period is ever cut
  // short or stretched.
  assign commit = pend_q && ((mode != MODE_RUN) || terminal);

  // Commit takes the old shadow before a same-edge write replaces it, which
  // leaves the new value pending.
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    clk_d     = clk_q;

    if (commit) begin
      div_act_d = div_shd_q;
      pend_d    = 1'b0;
    end
    if (i_wr) begin
      div_shd_d = i_wr_div;
      pend_d    = 1'b1;
    end

    unique case (mode)
      MODE_OFF, MODE_SYNC: begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
      MODE_PARK: begin
        cnt_d = '0;
      end
      MODE_RUN: begin
        if (terminal) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          clk_d  = ~clk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      div_act_q <= CNT_W'(DIV_RST);
      div_shd_q <= CNT_W'(DIV_RST);
      tick_q    <= 1'b0;
      clk_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
      pend_q    <= pend_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_clk     = clk_q;
  assign o_pending = pend_q;

endmodule

// File: rtl/div_bank.sv
// -----------------------------------------------------------------------------
// div_bank
// Bank of N_CH independent tick / clock dividers running off one clock.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous reset, active-high
//   i_en       per-channel run enable
//   i_sync     1-cycle strobe restarting all channel counters together
//   i_wr       divisor write strobe
//   i_wr_ch    channel targeted by the write (values >= N_CH are ignored)
//   i_wr_div   new divisor (0 parks the channel)
//   o_tick     per-channel 1-cycle terminal-count pulse
//   o_clk      per-channel divided clock, 50% duty
//   o_pending  per-channel shadow divisor not yet committed
// -----------------------------------------------------------------------------
module div_bank
  import div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_CH-1:0]  i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_clk,
  output logic [N_CH-1:0]  o_pending
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    logic wr_sel;

    // A channel index with no matching channel selects nothing, so writes
    // beyond the bank are dropped without side effects.
    assign wr_sel = i_wr && (i_wr_ch == CH_W'(g));

    div_chan #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_RST)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (i_en[g]),
      .i_sync   (i_sync),
      .i_wr     (wr_sel),
      .i_wr_div (i_wr_div),
      .o_tick   (o_tick[g]),
      .o_clk    (o_clk[g]),
      .o_pending(o_pending[g])
    );
  end

endmodule

// File: tb/tb_div_bank.sv
// -----------------------------------------------------------------------------
// tb_div_bank
// Directed bench for div_bank: a 4-channel instance for the main behaviour
// and a 3-channel instance so that an out-of-range channel index exists.
// -----------------------------------------------------------------------------
module tb_div_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;

  logic [3:0] en;
  logic       wr;
  logic [1:0] wr_ch;
  logic [7:0] wr_div;
  logic [3:0] tick;
  logic [3:0] clk_out;
  logic [3:0] pending;

  logic [2:0] en3;
  logic       wr3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_div3;
  logic [2:0] tick3;
  logic [2:0] clk_out3;
  logic [2:0] pending3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_bank #(.N_CH(4), .CNT_W(8), .DIV_RST(10)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_sync   (sync),
    .i_wr     (wr),
    .i_wr_ch  (wr_ch),
    .i_wr_div (wr_div),
    .o_tick   (tick),
    .o_clk    (clk_out),
    .o_pending(pending)
  );

  div_bank #(.N_CH(3), .CNT_W(8), .DIV_RST(10)) dut3 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en3),
    .i_sync   (sync),
    .i_wr     (wr3),
    .i_wr_ch  (wr_ch3),
    .i_wr_div (wr_div3),
    .o_tick   (tick3),
    .o_clk    (clk_out3),
    .o_pending(pending3)
  );

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle divisor write on the 4-channel bank; returns one edge later.
  task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] div);
    wr     = 1'b1;
    wr_ch  = ch;
    wr_div = div;
    @(negedge clk);
    wr     = 1'b0;
  endtask

  // Edges until tick[ch] is seen high; max_cycles+1 means it never came.
  task automatic measureGap(input int ch, input int max_cycles, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!tick[ch] && gap <= max_cycles);
  endtask

  initial begin
    int   gap;
    logic seen_tick;
    logic seen_clk;

    rst = 1'b1; sync = 1'b0;
    en = '0; wr = 1'b0; wr_ch = '0; wr_div = '0;
    en3 = '0; wr3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;
    waitCycles(2);
    checkOutput("rst_tick", tick, 4'h0);
    checkOutput("rst_clk", clk_out, 4'h0);
    checkOutput("rst_pending", pending, 4'h0);

    // Default divisor of 10 on every channel.
    rst = 1'b0; en = 4'hF; en3 = 3'h7;
    measureGap(0, 30, gap);
    checkOutput("first_tick_gap", gap, 10);
    checkOutput("first_tick_all", tick, 4'hF);
    checkOutput("first_clk_high", clk_out[0], 1'b1);
    measureGap(0, 30, gap);
    checkOutput("second_tick_gap", gap, 10);
    checkOutput("second_clk_low", clk_out[0], 1'b0);

    // Mid-period write to ch1 must wait for the running period to finish.
    waitCycles(4);
    applyStimulus(2'd1, 8'd3);
    checkOutput("wr_pending", pending, 4'b0010);
    measureGap(1, 30, gap);
    checkOutput("wr_old_period_rest", gap, 5);
    checkOutput("wr_boundary_ticks", tick, 4'hF);
    checkOutput("wr_committed", pending, 4'h0);
    measureGap(1, 30, gap);
    checkOutput("wr_new_gap_a", gap, 3);
    measureGap(1, 30, gap);
    checkOutput("wr_new_gap_b", gap, 3);

    // Divisors 4,4,6,1 then resync.
    applyStimulus(2'd0, 8'd4);
    applyStimulus(2'd1, 8'd4);
    applyStimulus(2'd2, 8'd6);
    applyStimulus(2'd3, 8'd1);
    sync = 1'b1;
    waitCycles(1);
    sync = 1'b0;
    checkOutput("sync_tick_clear", tick, 4'h0);
    checkOutput("sync_clk_clear", clk_out, 4'h0);
    checkOutput("sync_commit", pending, 4'h0);
    measureGap(0, 30, gap);
    checkOutput("sync_latency", gap + 1, 5);
    checkOutput("sync_aligned_ticks", tick, 4'b1011);
    checkOutput("sync_aligned_clks", clk_out, 4'b0011);
    waitCycles(2);
    checkOutput("div6_first_tick", tick, 4'b1100);

    // Park ch2: commit waits for its terminal count, then silence.
    applyStimulus(2'd2, 8'd0);
    checkOutput("park_pending", pending, 4'b0100);
    measureGap(2, 30, gap);
    checkOutput("park_commit_gap", gap, 5);
    checkOutput("park_committed", pending, 4'h0);
    checkOutput("park_clk_value", clk_out[2], 1'b0);
    seen_tick = 1'b0;
    seen_clk  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_tick |= tick[2];
      seen_clk  |= clk_out[2];
    end
    checkOutput("park_no_tick", seen_tick, 1'b0);
    checkOutput("park_clk_frozen", seen_clk, 1'b0);

    // Un-park ch2 with divisor 5: commits on the very next edge.
    applyStimulus(2'd2, 8'd5);
    checkOutput("unpark_pending", pending[2], 1'b1);
    waitCycles(1);
    checkOutput("unpark_committed", pending[2], 1'b0);
    measureGap(2, 30, gap);
    checkOutput("unpark_gap_a", gap, 5);
    measureGap(2, 30, gap);
    checkOutput("unpark_gap_b", gap, 5);

    // Drop en[0] for three cycles mid-count.
    waitCycles(6);
    checkOutput("en_pre_clk", clk_out[0], 1'b1);
    en = 4'b1110;
    waitCycles(1);
    checkOutput("en_off_tick", tick[0], 1'b0);
    checkOutput("en_off_clk", clk_out[0], 1'b0);
    waitCycles(2);
    en = 4'hF;
    measureGap(0, 30, gap);
    checkOutput("en_restart_gap", gap, 4);
    checkOutput("en_restart_clk", clk_out[0], 1'b1);

    // Reset with writes pending, including one landing on ch2's terminal count.
    applyStimulus(2'd1, 8'd7);
    applyStimulus(2'd2, 8'd9);
    checkOutput("pre_rst_pending", pending, 4'b0110);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("mid_rst_tick", tick, 4'h0);
    checkOutput("mid_rst_clk", clk_out, 4'h0);
    checkOutput("mid_rst_pending", pending, 4'h0);
    checkOutput("mid_rst_clk3", clk_out3, 3'h0);
    checkOutput("mid_rst_pending3", pending3, 3'h0);
    rst = 1'b0;
    measureGap(1, 30, gap);
    checkOutput("post_rst_gap", gap, 10);
    checkOutput("post_rst_ticks", tick, 4'hF);
    checkOutput("post_rst_ticks3", tick3, 3'h7);

    // Out-of-range channel on the 3-channel bank must change nothing.
    wr3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 8'd2;
    waitCycles(1);
    wr3 = 1'b0;
    checkOutput("oor_pending3", pending3, 3'h0);
    waitCycles(9);
    checkOutput("oor_period3", tick3, 3'h7);

    // Sync and write to ch0 on the same edge: old shadow commits, new one waits.
    applyStimulus(2'd0, 8'd2);
    sync = 1'b1; wr = 1'b1; wr_ch = 2'd0; wr_div = 8'd3;
    waitCycles(1);
    sync = 1'b0; wr = 1'b0;
    checkOutput("sync_wr_pending", pending, 4'b0001);
    measureGap(0, 30, gap);
    checkOutput("sync_wr_old_div", gap, 2);
    checkOutput("sync_wr_committed", pending[0], 1'b0);
    measureGap(0, 30, gap);
    checkOutput("sync_wr_new_div", gap, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
